// File: rtl/trap_controller_pkg.sv
// trap_controller_pkg
// Shared definitions for the user-mode trap sequencer:
//   - interrupt cause codes (low bits of ucause)
//   - ustatus bit positions
//   - generic CSR write address used for the ustatus update
//   - FSM state and accepted-event encodings
package trap_controller_pkg;

    // Interrupt cause codes
    localparam logic [3:0] CAUSE_USI = 4'd0;
    localparam logic [3:0] CAUSE_UTI = 4'd4;
    localparam logic [3:0] CAUSE_UEI = 4'd8;

    // ustatus bit indices
    localparam int UIE  = 0;
    localparam int UPIE = 4;

    localparam logic [11:0] ADDR_USTATUS = 12'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SAVE,
        ST_STATUS,
        ST_REDIRECT
    } state_e;

    typedef enum logic [1:0] {
        EV_NONE,
        EV_EXC,
        EV_URET,
        EV_IRQ
    } event_e;

endpackage

// File: rtl/trap_controller_if.sv
// trap_controller_if
// Bundles every non-clock signal of the trap controller.
//   Core side : exc_valid/exc_code/exc_pc/exc_tval, uret_valid,
//               irq_software/irq_timer/irq_external, next_pc,
//               redirect_valid/redirect_pc, stall
//   CSR side  : csr_ustatus/csr_utvec/csr_uepc (read-outs),
//               trap_save_we/trap_uepc/trap_ucause/trap_utval (simultaneous write),
//               status_we/status_addr/status_wdata (generic write)
// master = the trap controller, slave = the core/CSR file driving its inputs.
interface trap_controller_if;
    logic        exc_valid;
    logic [3:0]  exc_code;
    logic [31:0] exc_pc;
    logic [31:0] exc_tval;
    logic        uret_valid;
    logic        irq_software;
    logic        irq_timer;
    logic        irq_external;
    logic [31:0] next_pc;
    logic [31:0] csr_ustatus;
    logic [31:0] csr_utvec;
    logic [31:0] csr_uepc;

    logic        trap_save_we;
    logic [31:0] trap_uepc;
    logic [31:0] trap_ucause;
    logic [31:0] trap_utval;
    logic        status_we;
    logic [11:0] status_addr;
    logic [31:0] status_wdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;

    modport master (
        input  exc_valid, exc_code, exc_pc, exc_tval, uret_valid,
               irq_software, irq_timer, irq_external, next_pc,
               csr_ustatus, csr_utvec, csr_uepc,
        output trap_save_we, trap_uepc, trap_ucause, trap_utval,
               status_we, status_addr, status_wdata,
               redirect_valid, redirect_pc, stall
    );

    modport slave (
        output exc_valid, exc_code, exc_pc, exc_tval, uret_valid,
               irq_software, irq_timer, irq_external, next_pc,
               csr_ustatus, csr_utvec, csr_uepc,
        input  trap_save_we, trap_uepc, trap_ucause, trap_utval,
               status_we, status_addr, status_wdata,
               redirect_valid, redirect_pc, stall
    );
endinterface

// File: rtl/trap_controller_priority_encoder.sv
// trap_priority_encoder
// Combinational event selection for the trap controller.
//   i_exc_valid, i_uret_valid      : synchronous exception / uret retiring
//   i_irq_*                        : level interrupt requests
//   i_uie                          : ustatus.UIE, gates all interrupts
//   o_event                        : selected event (EV_NONE if nothing acceptable)
//   o_code                         : interrupt cause code (0 for non-interrupts)
module trap_priority_encoder
    import trap_controller_pkg::*;
(
    input  logic       i_exc_valid,
    input  logic       i_uret_valid,
    input  logic       i_irq_software,
    input  logic       i_irq_timer,
    input  logic       i_irq_external,
    input  logic       i_uie,
    output event_e     o_event,
    output logic [3:0] o_code
);

    // Priority: exception > uret > external > software > timer.
    always_comb begin
        o_event = EV_NONE;
        o_code  = 4'd0;
        if (i_exc_valid) begin
            o_event = EV_EXC;
        end else if (i_uret_valid) begin
            o_event = EV_URET;
        end else if (i_uie && i_irq_external) begin
            o_event = EV_IRQ;
            o_code  = CAUSE_UEI;
        end else if (i_uie && i_irq_software) begin
            o_event = EV_IRQ;
            o_code  = CAUSE_USI;
        end else if (i_uie && i_irq_timer) begin
            o_event = EV_IRQ;
            o_code  = CAUSE_UTI;
        end
    end

endmodule

// File: rtl/trap_controller.sv
// trap_controller
// User-mode trap sequencer. Accepts exceptions, user interrupts and uret in
// IDLE, then walks SAVE (uepc/ucause/utval write) -> STATUS (ustatus write)
// -> REDIRECT (PC redirect). uret skips SAVE.
//   core_clock : clock, rising edge
//   reset      : synchronous, active-high
//   bus        : trap_controller_if.master (core and CSR file signals)
// All bus outputs are registered except stall.
module trap_controller
    import trap_controller_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h00400000
) (
    input  logic              core_clock,
    input  logic              reset,
    trap_controller_if.master bus
);

    state_e      r_state;
    state_e      w_next;
    event_e      w_event;
    logic [3:0]  w_code;
    logic        w_accept;

    // Snapshot taken at accept; CSR changes mid-sequence are ignored.
    logic [31:0] r_ustatus;
    logic [31:0] r_utvec;
    logic [31:0] r_ret_pc;
    logic        r_is_uret;
    logic        r_is_irq;
    logic [3:0]  r_code;

    logic        r_save_we;
    logic [31:0] r_trap_uepc;
    logic [31:0] r_trap_ucause;
    logic [31:0] r_trap_utval;
    logic        r_status_we;
    logic [31:0] r_status_wdata;
    logic        r_redirect_valid;
    logic [31:0] r_redirect_pc;

    logic [31:0] w_snap;
    logic        w_uret_now;
    logic [31:0] w_status_new;
    logic [31:0] w_vec_off;
    logic [31:0] w_target;

    trap_priority_encoder u_prio (
        .i_exc_valid    (bus.exc_valid),
        .i_uret_valid   (bus.uret_valid),
        .i_irq_software (bus.irq_software),
        .i_irq_timer    (bus.irq_timer),
        .i_irq_external (bus.irq_external),
        .i_uie          (bus.csr_ustatus[UIE]),
        .o_event        (w_event),
        .o_code         (w_code)
    );

    assign w_accept = (r_state == ST_IDLE) && (w_event != EV_NONE);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                case (w_event)
                    EV_EXC, EV_IRQ: w_next = ST_SAVE;
                    EV_URET:        w_next = ST_STATUS;
                    default:        w_next = ST_IDLE;
                endcase
            end
            ST_SAVE:     w_next = ST_STATUS;
            ST_STATUS:   w_next = ST_REDIRECT;
            ST_REDIRECT: w_next = ST_IDLE;
            default:     w_next = ST_IDLE;
        endcase
    end

    // uret enters STATUS straight from IDLE, before the snapshot registers
    // are loaded, so the ustatus update reads the live CSR in that case.
    assign w_snap     = (r_state == ST_IDLE) ? bus.csr_ustatus : r_ustatus;
    assign w_uret_now = (r_state == ST_IDLE) ? (w_event == EV_URET) : r_is_uret;

    always_comb begin
        w_status_new = w_snap;
        if (w_uret_now) begin
            w_status_new[UIE]  = w_snap[UPIE];
            w_status_new[UPIE] = 1'b1;
        end else begin
            w_status_new[UPIE] = w_snap[UIE];
            w_status_new[UIE]  = 1'b0;
        end
    end

    // Vectored mode offsets interrupts by 4*code; sum wraps modulo 2^32.
    assign w_vec_off = (r_utvec[1:0] == 2'b01 && r_is_irq) ? {26'd0, r_code, 2'b00} : 32'd0;
    assign w_target  = r_is_uret ? r_ret_pc : ({r_utvec[31:2], 2'b00} + w_vec_off);

    always_ff @(posedge core_clock) begin
        if (reset) begin
            r_state          <= ST_IDLE;
            r_ustatus        <= '0;
            r_utvec          <= '0;
            r_ret_pc         <= '0;
            r_is_uret        <= 1'b0;
            r_is_irq         <= 1'b0;
            r_code           <= '0;
            r_save_we        <= 1'b0;
            r_trap_uepc      <= '0;
            r_trap_ucause    <= '0;
            r_trap_utval     <= '0;
            r_status_we      <= 1'b0;
            r_status_wdata   <= '0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= RESET_PC;
        end else begin
            r_state          <= w_next;
            r_save_we        <= (w_next == ST_SAVE);
            r_status_we      <= (w_next == ST_STATUS);
            r_redirect_valid <= (w_next == ST_REDIRECT);

            if (w_accept) begin
                r_ustatus <= bus.csr_ustatus;
                r_utvec   <= bus.csr_utvec;
                r_ret_pc  <= bus.csr_uepc;
                r_is_uret <= (w_event == EV_URET);
                r_is_irq  <= (w_event == EV_IRQ);
                r_code    <= w_code;
                if (w_event == EV_EXC) begin
                    r_trap_uepc   <= bus.exc_pc;
                    r_trap_ucause <= {28'd0, bus.exc_code};
                    r_trap_utval  <= bus.exc_tval;
                end else if (w_event == EV_IRQ) begin
                    r_trap_uepc   <= bus.next_pc;
                    r_trap_ucause <= {1'b1, 27'd0, w_code};
                    r_trap_utval  <= 32'd0;
                end
            end

            if (w_next == ST_STATUS)
                r_status_wdata <= w_status_new;
            if (w_next == ST_REDIRECT)
                r_redirect_pc <= w_target;
        end
    end

    assign bus.trap_save_we   = r_save_we;
    assign bus.trap_uepc      = r_trap_uepc;
    assign bus.trap_ucause    = r_trap_ucause;
    assign bus.trap_utval     = r_trap_utval;
    assign bus.status_we      = r_status_we;
    assign bus.status_addr    = ADDR_USTATUS;
    assign bus.status_wdata   = r_status_wdata;
    assign bus.redirect_valid = r_redirect_valid;
    assign bus.redirect_pc    = r_redirect_pc;
    assign bus.stall          = w_accept || (r_state != ST_IDLE);

endmodule

// File: doc/trap_controller.md
# trap_controller

User-mode trap sequencer between the core's control path and the CSR register file. It accepts synchronous exceptions, user interrupts and `uret`, then drives the CSR file's simultaneous write port (uepc/ucause/utval) and its generic write port (ustatus). It returns a PC redirect and stalls the core for the whole sequence. It reads ustatus, utvec and uepc through the CSR file's dedicated read outputs.

## Interface
Parameters:
- `RESET_PC`, 32'h00400000: reset value of `redirect_pc`.

Ports:
- `core_clock` in 1: core clock; all state updates on the rising edge.
- `reset` in 1: reset, synchronous and active-high.
- `exc_valid` in 1: synchronous exception in the current instruction.
- `exc_code` in 4: exception cause code.
- `exc_pc` in 32: PC of the faulting instruction.
- `exc_tval` in 32: faulting address or instruction.
- `uret_valid` in 1: `uret` retiring.
- `irq_software`, `irq_timer`, `irq_external` in 1 each: level interrupt requests.
- `next_pc` in 32: PC of the next instruction, used for interrupts.
- `csr_ustatus`, `csr_utvec`, `csr_uepc` in 32 each: direct CSR read-outs.
- `trap_save_we` out 1: drives the CSR file's simultaneous-write strobe.
- `trap_uepc`, `trap_ucause`, `trap_utval` out 32 each: simultaneous write data.
- `status_we` out 1: generic CSR write enable.
- `status_addr` out 12: generic CSR write address; always 12'd0 (ustatus).
- `status_wdata` out 32: new ustatus value.
- `redirect_valid` out 1: one-cycle PC redirect strobe.
- `redirect_pc` out 32: redirect target.
- `stall` out 1: freeze fetch, decode and execute.

## Operation
- FSM states: IDLE, SAVE, STATUS, REDIRECT.
- Events are accepted only in IDLE. Priority, highest first:
  - `exc_valid`
  - `uret_valid`
  - `irq_external` (code 8)
  - `irq_software` (code 0)
  - `irq_timer` (code 4)
- Interrupts are taken only when `csr_ustatus[0]` (UIE) = 1. Masked interrupts are ignored.
- Exception accepted: latch uepc=`exc_pc`, ucause={28'b0,`exc_code`}, utval=`exc_tval`. Next state SAVE.
- Interrupt accepted: latch uepc=`next_pc`, ucause={1'b1,27'b0,code}, utval=0. Next state SAVE.
- `uret` accepted: next state STATUS, SAVE is skipped.
- The ustatus snapshot and utvec/uepc targets are latched at accept. Later CSR changes during the sequence are ignored.
- SAVE: `trap_save_we`=1 with the latched data. Next state STATUS.
- STATUS: `status_we`=1.
  - Trap: wdata = snapshot with bit4 (UPIE) set to the old bit0 and bit0 cleared.
  - uret: wdata = snapshot with bit0 set to the old bit4 and bit4 set.
  - All other bits are unchanged. Next state REDIRECT.
- REDIRECT: `redirect_valid`=1. Next state IDLE.
  - Trap target = {utvec[31:2],2'b00}.
  - If utvec[1:0]=2'b01 and the event is an interrupt, add 4×code. Modulo 2^32, wraps silently.
  - uret target = latched uepc.
- Events arriving while not in IDLE are ignored. The core must be stalled, so they are bench assertion errors.
- `exc_valid` and `uret_valid` together: the exception wins, and uepc is the uret PC.

## Timing
- Reset: state IDLE; all strobes, `stall` and data outputs are 0; `redirect_pc`=`RESET_PC`.
- Reset mid-sequence aborts it. No further CSR writes or redirect are issued, and writes already issued stand.
- All outputs are registered except `stall`.
- `stall` = (IDLE and an acceptable event present) or (state ≠ IDLE). It deasserts the cycle after REDIRECT.
- Trap latency: accept edge to `trap_save_we` is 1 cycle, `status_we` 2 cycles, `redirect_valid` 3 cycles.
- uret latency: `status_we` at +1, `redirect_valid` at +2.
- Each strobe is high for exactly one cycle. Back-to-back events are possible from the cycle after REDIRECT.

## Structure
- The shared core package holds:
  - cause code constants (CAUSE_USI=0, CAUSE_UTI=4, CAUSE_UEI=8);
  - ustatus bit indices (UIE=0, UPIE=4);
  - CSR address constant ADDR_USTATUS=12'd0;
  - FSM state enum.
- One sub-module: `trap_priority_encoder`, a combinational block that selects the event and code from the request lines and UIE.

## Test plan
1. Exception: `exc_valid`, code 2, pc 0x00400010, tval 0x00000013, utvec 0x00400100 → save strobe with uepc 0x00400010, ucause 2, utval 0x13; ustatus 0x1 → 0x10; redirect 0x00400100 at +3.
2. Vectored timer interrupt: UIE=1, utvec 0x00400101, `next_pc` 0x00400020 → ucause 0x80000004, uepc 0x00400020, redirect 0x00400110.
3. Masked interrupt: UIE=0, `irq_external`=1 for 10 cycles → no strobes, `stall`=0.
4. `uret`: ustatus 0x10, uepc 0x00400024 → status write 0x11; redirect 0x00400024 at +2; no save strobe.
5. Simultaneous external, software and timer interrupts plus `uret`, UIE=1 → `uret` taken; then external (code 8) on the next accept after UIE is restored.
6. Reset asserted in STATUS → no `status_we`, no redirect; outputs 0, `redirect_pc`=`RESET_PC` the next cycle.
